// File: rtl/sync_gen_pkg.sv
// Shared timing defaults, flag bundle and interval-membership rule for sync_gen.
package sync_pkg;

  localparam int unsigned DEF_HW            = 9;
  localparam int unsigned DEF_VW            = 9;
  localparam int unsigned DEF_H_TOTAL       = 455;
  localparam int unsigned DEF_H_BLANK_START = 0;
  localparam int unsigned DEF_H_BLANK_END   = 80;
  localparam int unsigned DEF_H_SYNC_START  = 32;
  localparam int unsigned DEF_H_SYNC_END    = 64;
  localparam int unsigned DEF_V_TOTAL       = 262;
  localparam int unsigned DEF_V_BLANK_START = 0;
  localparam int unsigned DEF_V_BLANK_END   = 16;
  localparam int unsigned DEF_V_SYNC_START  = 4;
  localparam int unsigned DEF_V_SYNC_END    = 8;

  // Registered decode flags; sync is stored already active-low.
  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hsync_n;
    logic vsync_n;
    logic line_end;
    logic frame_end;
  } sync_flags_t;

  // START<END: plain range; START>END: range wraps through zero; equal: never active.
  function automatic logic in_interval(input int unsigned cnt,
                                       input int unsigned start_v,
                                       input int unsigned end_v);
    logic r;
    if (start_v < end_v)
      r = (cnt >= start_v) && (cnt < end_v);
    else if (start_v > end_v)
      r = (cnt >= start_v) || (cnt < end_v);
    else
      r = 1'b0;
    return r;
  endfunction

  // True when a counter of width w can represent every value 0..total-1.
  function automatic logic fits(input int unsigned total, input int unsigned w);
    return (64'(total) <= (64'(1) << w));
  endfunction

endpackage

// File: rtl/sync_gen_if.sv
// Bundle of the sync_gen pixel-enable input and timing outputs.
interface sync_gen_if #(
  parameter int unsigned HW = 9,
  parameter int unsigned VW = 9
);
  logic          ce;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hblank;
  logic          _hblank;
  logic          vblank;
  logic          _vblank;
  logic          _hsync;
  logic          _vsync;
  logic          line_end;
  logic          frame_end;

  modport master (
    input  ce,
    output hcnt, vcnt, hblank, _hblank, vblank, _vblank,
           _hsync, _vsync, line_end, frame_end
  );

  modport slave (
    output ce,
    input  hcnt, vcnt, hblank, _hblank, vblank, _vblank,
           _hsync, _vsync, line_end, frame_end
  );
endinterface

// File: rtl/sync_gen_interval_decode.sv
// Combinational membership test of a counter value against one [START,END) interval.
module interval_decode
  import sync_pkg::*;
#(
  parameter int unsigned W     = 9,
  parameter int unsigned START = 0,
  parameter int unsigned END   = 0
) (
  input  logic [W-1:0] cnt,
  output logic         active
);

  assign active = in_interval(32'(cnt), START, END);

endmodule

// File: rtl/sync_gen.sv
// Horizontal/vertical raster counters with registered blank, sync and end-of-line/frame flags.
module sync_gen
  import sync_pkg::*;
#(
  parameter int unsigned HW            = DEF_HW,
  parameter int unsigned VW            = DEF_VW,
  parameter int unsigned H_TOTAL       = DEF_H_TOTAL,
  parameter int unsigned H_BLANK_START = DEF_H_BLANK_START,
  parameter int unsigned H_BLANK_END   = DEF_H_BLANK_END,
  parameter int unsigned H_SYNC_START  = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_END    = DEF_H_SYNC_END,
  parameter int unsigned V_TOTAL       = DEF_V_TOTAL,
  parameter int unsigned V_BLANK_START = DEF_V_BLANK_START,
  parameter int unsigned V_BLANK_END   = DEF_V_BLANK_END,
  parameter int unsigned V_SYNC_START  = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_END    = DEF_V_SYNC_END
) (
  input  logic          mclk,
  input  logic          _reset,
  input  logic          ce,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hblank,
  output logic          _hblank,
  output logic          vblank,
  output logic          _vblank,
  output logic          _hsync,
  output logic          _vsync,
  output logic          line_end,
  output logic          frame_end
);

  if (H_TOTAL == 0 || V_TOTAL == 0 ||
      !fits(H_TOTAL, HW) || !fits(V_TOTAL, VW) ||
      H_BLANK_START > H_TOTAL || H_BLANK_END > H_TOTAL ||
      H_SYNC_START  > H_TOTAL || H_SYNC_END  > H_TOTAL ||
      V_BLANK_START > V_TOTAL || V_BLANK_END > V_TOTAL ||
      V_SYNC_START  > V_TOTAL || V_SYNC_END  > V_TOTAL) begin : g_param_check
    $error("sync_gen: timing parameters exceed counter width or line/frame totals");
  end

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Decode of position (0,0), loaded while reset is held.
  localparam sync_flags_t RST_FLAGS = '{
    hblank:    in_interval(0, H_BLANK_START, H_BLANK_END),
    vblank:    in_interval(0, V_BLANK_START, V_BLANK_END),
    hsync_n:   !in_interval(0, H_SYNC_START, H_SYNC_END),
    vsync_n:   !in_interval(0, V_SYNC_START, V_SYNC_END),
    line_end:  (H_TOTAL == 1),
    frame_end: (H_TOTAL == 1) && (V_TOTAL == 1)
  };

  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          h_last;
  logic          v_last;
  logic          hb_d;
  logic          hs_d;
  logic          vb_d;
  logic          vs_d;
  sync_flags_t   flags;
  sync_flags_t   flags_next;

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // Next raster position: hold without ce, vertical steps only on the horizontal wrap.
  always_comb begin
    h_next = hcnt;
    v_next = vcnt;
    if (ce) begin
      if (h_last) begin
        h_next = '0;
        v_next = v_last ? '0 : vcnt + VW'(1);
      end else begin
        h_next = hcnt + HW'(1);
      end
    end
  end

  // Flags are decoded from the next position so the registered flags line up with the counters.
  interval_decode #(.W(HW), .START(H_BLANK_START), .END(H_BLANK_END))
    u_hblank (.cnt(h_next), .active(hb_d));
  interval_decode #(.W(HW), .START(H_SYNC_START),  .END(H_SYNC_END))
    u_hsync  (.cnt(h_next), .active(hs_d));
  interval_decode #(.W(VW), .START(V_BLANK_START), .END(V_BLANK_END))
    u_vblank (.cnt(v_next), .active(vb_d));
  interval_decode #(.W(VW), .START(V_SYNC_START),  .END(V_SYNC_END))
    u_vsync  (.cnt(v_next), .active(vs_d));

  // Assemble the flag word that will accompany the next position.
  always_comb begin
    flags_next           = RST_FLAGS;
    flags_next.hblank    = hb_d;
    flags_next.vblank    = vb_d;
    flags_next.hsync_n   = ~hs_d;
    flags_next.vsync_n   = ~vs_d;
    flags_next.line_end  = (h_next == H_LAST);
    flags_next.frame_end = (h_next == H_LAST) && (v_next == V_LAST);
  end

  // Counter and flag registers; with ce low the next values equal the current ones.
  always_ff @(posedge mclk or negedge _reset) begin
    if (!_reset) begin
      hcnt  <= '0;
      vcnt  <= '0;
      flags <= RST_FLAGS;
    end else begin
      hcnt  <= h_next;
      vcnt  <= v_next;
      flags <= flags_next;
    end
  end

  assign hblank    = flags.hblank;
  assign _hblank   = ~flags.hblank;
  assign vblank    = flags.vblank;
  assign _vblank   = ~flags.vblank;
  assign _hsync    = flags.hsync_n;
  assign _vsync    = flags.vsync_n;
  assign line_end  = flags.line_end;
  assign frame_end = flags.frame_end;

endmodule

// File: tb/tb_sync_gen.sv
// Scoreboard bench for sync_gen: four parameterisations share clock, reset and ce.
module tb_sync_gen;

  localparam int unsigned HT  [4] = '{455, 455, 20, 20};
  localparam int unsigned VT  [4] = '{262, 262, 12, 12};
  localparam int unsigned HBS [4] = '{0,   440, 0,  0};
  localparam int unsigned HBE [4] = '{80,  20,  4,  4};
  localparam int unsigned HSS [4] = '{32,  32,  2,  2};
  localparam int unsigned HSE [4] = '{64,  64,  5,  5};
  localparam int unsigned VBS [4] = '{0,   0,   0,  0};
  localparam int unsigned VBE [4] = '{16,  16,  2,  2};
  localparam int unsigned VSS [4] = '{4,   4,   4,  5};
  localparam int unsigned VSE [4] = '{8,   8,   8,  5};

  typedef struct packed {
    logic [3:0][8:0] h;
    logic [3:0][8:0] v;
    logic [3:0]      hb;
    logic [3:0]      vb;
    logic [3:0]      hs;
    logic [3:0]      vs;
    logic [3:0]      le;
    logic [3:0]      fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic cnt_en = 1'b0;
  event sample_ev;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned mh [4];
  int unsigned mv [4];
  exp_t sbq [$];

  int unsigned n_hb0 = 0, n_hs0 = 0, n_hb1 = 0, n_le0 = 0;
  int unsigned n_fe2 = 0, n_vs2 = 0, n_vs3 = 0, n_le2 = 0;

  always #5 clk = ~clk;

  sync_gen_if #(.HW(9), .VW(9)) if0 ();
  sync_gen_if #(.HW(9), .VW(9)) if1 ();
  sync_gen_if #(.HW(5), .VW(4)) if2 ();
  sync_gen_if #(.HW(5), .VW(4)) if3 ();

  assign if0.ce = ce;
  assign if1.ce = ce;
  assign if2.ce = ce;
  assign if3.ce = ce;

  sync_gen u0 (
    .mclk(clk), ._reset(rst_n), .ce(if0.ce), .hcnt(if0.hcnt), .vcnt(if0.vcnt),
    .hblank(if0.hblank), ._hblank(if0._hblank), .vblank(if0.vblank), ._vblank(if0._vblank),
    ._hsync(if0._hsync), ._vsync(if0._vsync), .line_end(if0.line_end), .frame_end(if0.frame_end)
  );

  sync_gen #(.H_BLANK_START(440), .H_BLANK_END(20)) u1 (
    .mclk(clk), ._reset(rst_n), .ce(if1.ce), .hcnt(if1.hcnt), .vcnt(if1.vcnt),
    .hblank(if1.hblank), ._hblank(if1._hblank), .vblank(if1.vblank), ._vblank(if1._vblank),
    ._hsync(if1._hsync), ._vsync(if1._vsync), .line_end(if1.line_end), .frame_end(if1.frame_end)
  );

  sync_gen #(.HW(5), .VW(4), .H_TOTAL(20), .H_BLANK_START(0), .H_BLANK_END(4),
             .H_SYNC_START(2), .H_SYNC_END(5), .V_TOTAL(12), .V_BLANK_START(0),
             .V_BLANK_END(2), .V_SYNC_START(4), .V_SYNC_END(8)) u2 (
    .mclk(clk), ._reset(rst_n), .ce(if2.ce), .hcnt(if2.hcnt), .vcnt(if2.vcnt),
    .hblank(if2.hblank), ._hblank(if2._hblank), .vblank(if2.vblank), ._vblank(if2._vblank),
    ._hsync(if2._hsync), ._vsync(if2._vsync), .line_end(if2.line_end), .frame_end(if2.frame_end)
  );

  sync_gen #(.HW(5), .VW(4), .H_TOTAL(20), .H_BLANK_START(0), .H_BLANK_END(4),
             .H_SYNC_START(2), .H_SYNC_END(5), .V_TOTAL(12), .V_BLANK_START(0),
             .V_BLANK_END(2), .V_SYNC_START(5), .V_SYNC_END(5)) u3 (
    .mclk(clk), ._reset(rst_n), .ce(if3.ce), .hcnt(if3.hcnt), .vcnt(if3.vcnt),
    .hblank(if3.hblank), ._hblank(if3._hblank), .vblank(if3.vblank), ._vblank(if3._vblank),
    ._hsync(if3._hsync), ._vsync(if3._vsync), .line_end(if3.line_end), .frame_end(if3.frame_end)
  );

  logic [8:0] ah [4];
  logic [8:0] av [4];
  logic [3:0] ahb, ahbn, avb, avbn, ahs, avs, ale, afe;

  assign ah[0] = 9'(if0.hcnt);
  assign ah[1] = 9'(if1.hcnt);
  assign ah[2] = 9'(if2.hcnt);
  assign ah[3] = 9'(if3.hcnt);
  assign av[0] = 9'(if0.vcnt);
  assign av[1] = 9'(if1.vcnt);
  assign av[2] = 9'(if2.vcnt);
  assign av[3] = 9'(if3.vcnt);
  assign ahb  = {if3.hblank,    if2.hblank,    if1.hblank,    if0.hblank};
  assign ahbn = {if3._hblank,   if2._hblank,   if1._hblank,   if0._hblank};
  assign avb  = {if3.vblank,    if2.vblank,    if1.vblank,    if0.vblank};
  assign avbn = {if3._vblank,   if2._vblank,   if1._vblank,   if0._vblank};
  assign ahs  = {if3._hsync,    if2._hsync,    if1._hsync,    if0._hsync};
  assign avs  = {if3._vsync,    if2._vsync,    if1._vsync,    if0._vsync};
  assign ale  = {if3.line_end,  if2.line_end,  if1.line_end,  if0.line_end};
  assign afe  = {if3.frame_end, if2.frame_end, if1.frame_end, if0.frame_end};

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic iv(input int unsigned c, input int unsigned s, input int unsigned e);
    if (s < e) return (c >= s) && (c < e);
    if (s > e) return (c >= s) || (c < e);
    return 1'b0;
  endfunction

  task automatic model_edge(input logic ce_v, input logic rst_v);
    for (int i = 0; i < 4; i++) begin
      if (!rst_v) begin
        mh[i] = 0;
        mv[i] = 0;
      end else if (ce_v) begin
        if (mh[i] == HT[i] - 1) begin
          mh[i] = 0;
          mv[i] = (mv[i] == VT[i] - 1) ? 0 : mv[i] + 1;
        end else begin
          mh[i] = mh[i] + 1;
        end
      end
    end
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.h[i]  = 9'(mh[i]);
      e.v[i]  = 9'(mv[i]);
      e.hb[i] = iv(mh[i], HBS[i], HBE[i]);
      e.vb[i] = iv(mv[i], VBS[i], VBE[i]);
      e.hs[i] = !iv(mh[i], HSS[i], HSE[i]);
      e.vs[i] = !iv(mv[i], VSS[i], VSE[i]);
      e.le[i] = (mh[i] == HT[i] - 1);
      e.fe[i] = (mh[i] == HT[i] - 1) && (mv[i] == VT[i] - 1);
    end
    return e;
  endfunction

  task automatic step(input logic ce_v);
    ce = ce_v;
    @(posedge clk);
    #1;
    model_edge(ce_v, rst_n);
    sbq.push_back(make_exp());
  endtask

  // Monitor: pop every queued expectation when the DUT outputs are stable.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("hcnt[%0d]", i),      ah[i],   e.h[i]);
          chk($sformatf("vcnt[%0d]", i),      av[i],   e.v[i]);
          chk($sformatf("hblank[%0d]", i),    ahb[i],  e.hb[i]);
          chk($sformatf("_hblank[%0d]", i),   ahbn[i], !e.hb[i]);
          chk($sformatf("vblank[%0d]", i),    avb[i],  e.vb[i]);
          chk($sformatf("_vblank[%0d]", i),   avbn[i], !e.vb[i]);
          chk($sformatf("_hsync[%0d]", i),    ahs[i],  e.hs[i]);
          chk($sformatf("_vsync[%0d]", i),    avs[i],  e.vs[i]);
          chk($sformatf("line_end[%0d]", i),  ale[i],  e.le[i]);
          chk($sformatf("frame_end[%0d]", i), afe[i],  e.fe[i]);
        end
        if (cnt_en) begin
          if (ahb[0] && av[0] == 0) n_hb0++;
          if (!ahs[0] && av[0] == 0) n_hs0++;
          if (ahb[1] && av[1] == 0) n_hb1++;
          if (ale[0]) n_le0++;
          if (afe[2]) n_fe2++;
          if (!avs[2]) n_vs2++;
          if (!avs[3]) n_vs3++;
          if (ale[2]) n_le2++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      mh[i] = 0;
      mv[i] = 0;
    end

    // Reset held across enabled edges; release, then count 480 samples from (0,0).
    step(1'b1);
    @(negedge clk);
    #1;
    cnt_en = 1'b1;
    step(1'b1);
    rst_n = 1'b1;
    for (int n = 0; n < 479; n++) step(1'b1);
    @(negedge clk);
    #1;
    cnt_en = 1'b0;

    chk("u0_hblank_per_line", n_hb0, 80);
    chk("u0_hsync_low_per_line", n_hs0, 32);
    chk("u1_wrap_hblank_per_line", n_hb1, 35);
    chk("u0_line_end_count", n_le0, 1);
    chk("u2_frame_end_count", n_fe2, 2);
    chk("u2_vsync_low_clocks", n_vs2, 160);
    chk("u3_vsync_low_clocks", n_vs3, 0);
    chk("u2_line_end_count", n_le2, 24);

    // Clock-enable stall from hcnt=10.
    for (int n = 0; n < 1000 && mh[0] != 10; n++) step(1'b1);
    @(negedge clk);
    #1;
    chk("ce_start_h10", if0.hcnt, 10);
    step(1'b1);
    @(negedge clk);
    #1;
    chk("ce_seq0", if0.hcnt, 11);
    step(1'b0);
    @(negedge clk);
    #1;
    chk("ce_seq1", if0.hcnt, 11);
    chk("ce_hold_hblank1", if0.hblank, 1);
    step(1'b0);
    @(negedge clk);
    #1;
    chk("ce_seq2", if0.hcnt, 11);
    chk("ce_hold_hsync2", if0._hsync, 1);
    step(1'b1);
    @(negedge clk);
    #1;
    chk("ce_seq3", if0.hcnt, 12);

    // Asynchronous reset in the middle of the horizontal sync pulse.
    for (int n = 0; n < 1000 && mh[0] != 40; n++) step(1'b1);
    @(negedge clk);
    #1;
    chk("pre_reset_h40", if0.hcnt, 40);
    chk("pre_reset_hsync_low", if0._hsync, 0);
    rst_n = 1'b0;
    #1;
    model_edge(1'b1, 1'b0);
    sbq.push_back(make_exp());
    ->sample_ev;
    chk("async_reset_hcnt", if0.hcnt, 0);
    chk("async_reset_hsync", if0._hsync, 1);
    step(1'b1);
    rst_n = 1'b1;
    step(1'b1);
    @(negedge clk);
    #1;
    chk("post_reset_hcnt", if0.hcnt, 1);

    // Random clock-enable pattern.
    for (int n = 0; n < 300; n++) step(1'($urandom_range(0, 1)));

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_gen.md
SYNC_GEN -- requirements
Module: sync_gen

Interface
REQ-001 SHALL have parameter HW, default 9, meaning horizontal counter width in bits.
REQ-002 SHALL have parameter VW, default 9, meaning vertical counter width in bits.
REQ-003 SHALL have parameter H_TOTAL, default 455, meaning clocks per line.
REQ-004 SHALL have parameters H_BLANK_START/H_BLANK_END, defaults 0/80, meaning horizontal blank interval.
REQ-005 SHALL have parameters H_SYNC_START/H_SYNC_END, defaults 32/64, meaning horizontal sync interval.
REQ-006 SHALL have parameter V_TOTAL, default 262, meaning lines per frame.
REQ-007 SHALL have parameters V_BLANK_START/V_BLANK_END, defaults 0/16, meaning vertical blank interval.
REQ-008 SHALL have parameters V_SYNC_START/V_SYNC_END, defaults 4/8, meaning vertical sync interval.
REQ-009 SHALL have port mclk  input  1  master clock; all state updates on its rising edge.
REQ-010 SHALL have port _reset  input  1  asynchronous, active-low reset.
REQ-011 SHALL have port ce  input  1  pixel enable; counters advance only when high.
REQ-012 SHALL have port hcnt  output  HW  current horizontal count.
REQ-013 SHALL have port vcnt  output  VW  current vertical count.
REQ-014 SHALL have ports hblank/_hblank  output  1 each  horizontal blank and its complement.
REQ-015 SHALL have ports vblank/_vblank  output  1 each  vertical blank and its complement.
REQ-016 SHALL have ports _hsync/_vsync  output  1 each  active-low sync pulses.
REQ-017 SHALL have ports line_end/frame_end  output  1 each  last-clock-of-line / last-clock-of-frame flags.

Function
REQ-018 On rising mclk with ce=1, hcnt SHALL increment by 1, wrapping H_TOTAL-1 -> 0.
REQ-019 vcnt SHALL increment only on the same enabled edge where hcnt wraps, wrapping V_TOTAL-1 -> 0; simultaneous wraps SHALL yield hcnt=0, vcnt=0.
REQ-020 With ce=0 all counters and outputs SHALL hold.
REQ-021 Interval membership SHALL be: START<END -> START<=cnt<END; START>END -> cnt>=START or cnt<END (wrap); START==END -> never active.
REQ-022 hblank/vblank/_hsync/_vsync SHALL be registered, computed from next-state counter values, so they are aligned with hcnt/vcnt in the same cycle (zero decode latency relative to counters).
REQ-023 _hsync SHALL be low iff hcnt in H sync interval; _vsync SHALL be low iff vcnt in V sync interval; sync is independent of blank.
REQ-024 _hblank/_vblank SHALL always equal the inverse of hblank/vblank.
REQ-025 line_end SHALL be high iff hcnt==H_TOTAL-1; frame_end iff line_end and vcnt==V_TOTAL-1.
REQ-026 Counter compares SHALL use full HW/VW width; parameters SHALL satisfy TOTAL<=2**W, all START/END<=TOTAL (elaboration-time check).

Reset
REQ-027 _reset low SHALL immediately force hcnt=0, vcnt=0 and outputs to the decode of (0,0), regardless of ce or mclk.
REQ-028 With defaults, reset values SHALL be hblank=1, _hblank=0, vblank=1, _vblank=0, _hsync=1, _vsync=1, line_end=0, frame_end=0.
REQ-029 Reset asserted mid-line or mid-sync SHALL abort the pulse; counting resumes from 0 on the first enabled edge after release.

Structure
REQ-030 Default timing constants and the interval-membership rule SHALL live in shared package sync_pkg.
REQ-031 Interval decode SHALL be one sub-module, interval_decode (parameters W, START, END), instantiated four times.

Verification
REQ-032 Defaults, ce=1, 1 line: hblank high hcnt 0..79, low 80..454; _hsync low exactly hcnt 32..63 (32 clocks).
REQ-033 Defaults, full frame: hcnt 454->0 increments vcnt; vcnt 261->0 wrap; frame_end single clock per 119,210-clock frame; _vsync low lines 4..7.
REQ-034 ce toggled 1,0,0,1 from hcnt=10: hcnt sequence 11,11,11,12; outputs unchanged during ce=0.
REQ-035 Wrap interval H_BLANK_START=440, H_BLANK_END=20: hblank high hcnt 440..454 and 0..19, low 20..439.
REQ-036 _reset pulsed low at hcnt=40 (inside sync): hcnt=0, _hsync=1 asynchronously; after release hcnt=1 on next enabled edge.
REQ-037 START==END on V sync: _vsync constantly 1 over two frames.
